draw_engine: RTL

Shape rasteriser directly downstream of the cursor/mode selection stage. Consumes the per-frame cursor point, the selected shape code (1 freehand, 2 line, 3 rectangle, 4 triangle), the 16-bit colour and the clear request. It turns completed strokes into a stream of single-pixel canvas writes over a valid/ready handshake toward the frame-buffer writer.

---
 rtl/draw_engine_pkg.sv | 33 +++
 rtl/draw_engine_line_gen.sv | 96 +++++++++
 rtl/draw_engine.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/draw_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : draw_engine_pkg
// Brief    : shape codes, colour constants and FSM encoding for draw_engine
// Revision : 1.0
// ============================================================================
package draw_engine_pkg;

    localparam logic [2:0]  DRAW_DIR    = 3'd1;
    localparam logic [2:0]  DRAW_LINE   = 3'd2;
    localparam logic [2:0]  DRAW_REC    = 3'd3;
    localparam logic [2:0]  DRAW_TRI    = 3'd4;
    localparam logic [15:0] TRANSPARENT = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROKE = 2'd1,
        ST_SEG    = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

    // Segments emitted at stroke end; freehand and no-op shapes emit none there.
    function automatic logic [2:0] seg_count(input logic [2:0] shape);
        case (shape)
            DRAW_LINE: seg_count = 3'd1;
            DRAW_REC:  seg_count = 3'd4;
            DRAW_TRI:  seg_count = 3'd3;
            default:   seg_count = 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/draw_engine_line_gen.sv
`default_nettype none
// ============================================================================
// Module   : draw_engine_line_gen
// Brief    : Bresenham segment walker, one pixel per accepted handshake
// Revision : 1.0
// ============================================================================
module draw_engine_line_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_abort,
    input  logic        i_start,
    input  logic [12:0] i_x0,
    input  logic [12:0] i_y0,
    input  logic [12:0] i_x1,
    input  logic [12:0] i_y1,
    output logic        o_pix_valid,
    input  logic        i_pix_ready,
    output logic [12:0] o_pix_x,
    output logic [12:0] o_pix_y,
    output logic        o_done
);
    logic               r_active;
    logic [12:0]        r_x, r_y, r_x1, r_y1;
    logic signed [14:0] r_dx, r_dy, r_err;
    logic               r_sx_neg, r_sy_neg;

    logic [12:0]        w_adx, w_ady, w_x_nx, w_y_nx;
    logic signed [14:0] w_dx, w_dy, w_e2, w_err_nx;
    logic               w_last, w_can_load;

    assign w_adx      = (i_x1 >= i_x0) ? (i_x1 - i_x0) : (i_x0 - i_x1);
    assign w_ady      = (i_y1 >= i_y0) ? (i_y1 - i_y0) : (i_y0 - i_y1);
    assign w_dx       = $signed({2'b00, w_adx});
    assign w_dy       = 15'sd0 - $signed({2'b00, w_ady});
    assign w_e2       = r_err <<< 1;
    assign w_last     = (r_x == r_x1) && (r_y == r_y1);
    assign o_done     = r_active && i_pix_ready && w_last;
    assign w_can_load = !r_active || o_done;

    assign o_pix_valid = r_active;
    assign o_pix_x     = r_x;
    assign o_pix_y     = r_y;

    always_comb begin
        w_err_nx = r_err;
        w_x_nx   = r_x;
        w_y_nx   = r_y;
        if (w_e2 >= r_dy) begin
            w_err_nx = w_err_nx + r_dy;
            w_x_nx   = r_sx_neg ? (r_x - 13'd1) : (r_x + 13'd1);
        end
        if (w_e2 <= r_dx) begin
            w_err_nx = w_err_nx + r_dx;
            w_y_nx   = r_sy_neg ? (r_y - 13'd1) : (r_y + 13'd1);
        end
    end

    // A start coinciding with the final pixel handshake loads back-to-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
        end else if (i_abort) begin
            r_active <= 1'b0;
        end else if (i_start && w_can_load) begin
            r_active <= 1'b1;
            r_x      <= i_x0;
            r_y      <= i_y0;
            r_x1     <= i_x1;
            r_y1     <= i_y1;
            r_dx     <= w_dx;
            r_dy     <= w_dy;
            r_err    <= w_dx + w_dy;
            r_sx_neg <= (i_x1 < i_x0);
            r_sy_neg <= (i_y1 < i_y0);
        end else if (r_active && i_pix_ready) begin
            if (w_last) begin
                r_active <= 1'b0;
            end else begin
                r_x   <= w_x_nx;
                r_y   <= w_y_nx;
                r_err <= w_err_nx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/draw_engine.sv
`default_nettype none
// ============================================================================
// Module   : draw_engine
// Brief    : turns cursor strokes into single-pixel frame-buffer writes
// Revision : 1.0
// ============================================================================
module draw_engine
    import draw_engine_pkg::*;
#(
    parameter int CANVAS_W   = 720,
    parameter int CANVAS_H   = 600,
    parameter int GAP_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_pt_valid,
    input  logic [12:0] i_X_pos,
    input  logic [12:0] i_Y_pos,
    input  logic        i_frame_end,
    input  logic [2:0]  i_draw_shape,
    input  logic [15:0] i_color,
    input  logic        i_clear,
    output logic        o_wr_valid,
    input  logic        i_wr_ready,
    output logic [12:0] o_wr_x,
    output logic [12:0] o_wr_y,
    output logic [15:0] o_wr_color,
    output logic        o_busy
);
    localparam logic [12:0]        c_x_max    = 13'(CANVAS_W - 1);
    localparam logic [12:0]        c_y_max    = 13'(CANVAS_H - 1);
    localparam int                 c_gap_w    = $clog2(GAP_FRAMES + 1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_FRAMES - 1);

    state_t               r_state, w_state_next;
    logic [12:0]          r_ax, r_ay, r_bx, r_by, r_clr_x, r_clr_y;
    logic [2:0]           r_shape, r_seg_idx;
    logic [15:0]          r_color;
    logic [c_gap_w-1:0]   r_gap;
    logic                 r_clr_prev;

    logic [12:0] w_px, w_py, w_apx, w_x0, w_y0, w_x1, w_y1;
    logic [13:0] w_apex_sum;
    logic [2:0]  w_shape, w_nseg;
    logic [1:0]  w_idx;
    logic        w_clr_edge, w_accept, w_free_pt, w_stroke_end, w_seg_end_start;
    logic        w_seg_more, w_clr_last, w_lg_start, w_lg_ready;
    logic        w_lg_valid, w_lg_done;
    logic [12:0] w_lg_x, w_lg_y;

    assign w_px            = (i_X_pos > c_x_max) ? c_x_max : i_X_pos;
    assign w_py            = (i_Y_pos > c_y_max) ? c_y_max : i_Y_pos;
    assign w_clr_edge      = i_clear && !r_clr_prev;
    assign w_accept        = i_pt_valid && !i_clear &&
                             (r_state == ST_IDLE || r_state == ST_STROKE);
    assign w_shape         = (r_state == ST_IDLE) ? i_draw_shape : r_shape;
    assign w_free_pt       = w_accept && (w_shape == DRAW_DIR);
    assign w_nseg          = seg_count(r_shape);
    assign w_stroke_end    = (r_state == ST_STROKE) && i_frame_end && !w_accept &&
                             (r_gap == c_gap_last);
    assign w_seg_end_start = w_stroke_end && (w_nseg != 3'd0);
    assign w_seg_more      = (r_state == ST_SEG) && w_lg_done && (r_seg_idx < w_nseg);
    assign w_clr_last      = (r_clr_x == c_x_max) && (r_clr_y == c_y_max);
    assign w_apex_sum      = {1'b0, r_ax} + {1'b0, r_bx};
    assign w_apx           = 13'(w_apex_sum >> 1);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_clr_edge) begin
            w_state_next = ST_CLEAR;
        end else begin
            case (r_state)
                ST_IDLE:   if (w_accept) w_state_next = w_free_pt ? ST_SEG : ST_STROKE;
                ST_STROKE: begin
                    if (w_free_pt)         w_state_next = ST_SEG;
                    else if (w_stroke_end) w_state_next = (w_nseg != 3'd0) ? ST_SEG : ST_IDLE;
                end
                ST_SEG: begin
                    if (w_lg_done) begin
                        if (r_shape == DRAW_DIR) w_state_next = ST_STROKE;
                        else if (!w_seg_more)    w_state_next = ST_IDLE;
                    end
                end
                ST_CLEAR:  if (i_wr_ready && w_clr_last) w_state_next = ST_IDLE;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    // Segment endpoint mux: freehand uses prev->P, stroke shapes index the list.
    always_comb begin
        w_lg_start = !w_clr_edge && (w_free_pt || w_seg_end_start || w_seg_more);
        w_idx      = w_seg_more ? r_seg_idx[1:0] : 2'd0;
        w_x0 = r_ax; w_y0 = r_ay; w_x1 = r_bx; w_y1 = r_by;
        if (w_free_pt) begin
            w_x0 = (r_state == ST_IDLE) ? w_px : r_bx;
            w_y0 = (r_state == ST_IDLE) ? w_py : r_by;
            w_x1 = w_px;
            w_y1 = w_py;
        end else if (r_shape == DRAW_REC) begin
            case (w_idx)
                2'd0:    begin w_x0 = r_ax; w_y0 = r_ay; w_x1 = r_bx; w_y1 = r_ay; end
                2'd1:    begin w_x0 = r_bx; w_y0 = r_ay; w_x1 = r_bx; w_y1 = r_by; end
                2'd2:    begin w_x0 = r_bx; w_y0 = r_by; w_x1 = r_ax; w_y1 = r_by; end
                default: begin w_x0 = r_ax; w_y0 = r_by; w_x1 = r_ax; w_y1 = r_ay; end
            endcase
        end else if (r_shape == DRAW_TRI) begin
            case (w_idx)
                2'd0:    begin w_x0 = w_apx; w_y0 = r_ay; w_x1 = r_ax;  w_y1 = r_by; end
                2'd1:    begin w_x0 = r_ax;  w_y0 = r_by; w_x1 = r_bx;  w_y1 = r_by; end
                default: begin w_x0 = r_bx;  w_y0 = r_by; w_x1 = w_apx; w_y1 = r_ay; end
            endcase
        end
        w_lg_ready = i_wr_ready && (r_state != ST_CLEAR);
        o_busy     = (r_state == ST_SEG) || (r_state == ST_CLEAR);
        o_wr_valid = (r_state == ST_CLEAR) ? 1'b1        : w_lg_valid;
        o_wr_x     = (r_state == ST_CLEAR) ? r_clr_x     : w_lg_x;
        o_wr_y     = (r_state == ST_CLEAR) ? r_clr_y     : w_lg_y;
        o_wr_color = (r_state == ST_CLEAR) ? TRANSPARENT : r_color;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ax <= '0; r_ay <= '0; r_bx <= '0; r_by <= '0;
            r_shape    <= '0;
            r_color    <= '0;
            r_gap      <= '0;
            r_seg_idx  <= '0;
            r_clr_prev <= 1'b0;
            r_clr_x    <= '0;
            r_clr_y    <= '0;
        end else begin
            r_clr_prev <= i_clear;
            if (w_clr_edge) begin
                r_clr_x   <= '0;
                r_clr_y   <= '0;
                r_gap     <= '0;
                r_seg_idx <= '0;
            end else begin
                if (r_state == ST_CLEAR && i_wr_ready) begin
                    if (r_clr_x == c_x_max) begin
                        r_clr_x <= '0;
                        r_clr_y <= (r_clr_y == c_y_max) ? 13'd0 : r_clr_y + 13'd1;
                    end else begin
                        r_clr_x <= r_clr_x + 13'd1;
                    end
                end
                if (w_accept) begin
                    if (r_state == ST_IDLE) begin
                        r_ax    <= w_px;
                        r_ay    <= w_py;
                        r_shape <= i_draw_shape;
                        r_color <= i_color;
                    end
                    r_bx  <= w_px;
                    r_by  <= w_py;
                    r_gap <= '0;
                end else if (r_state == ST_STROKE && i_frame_end) begin
                    r_gap <= w_stroke_end ? '0 : r_gap + 1'b1;
                end
                if (w_seg_end_start) r_seg_idx <= 3'd1;
                else if (w_seg_more) r_seg_idx <= r_seg_idx + 3'd1;
            end
        end
    end

    draw_engine_line_gen u_line_gen (
        .clk         (clk),
        .rst         (rst),
        .i_abort     (w_clr_edge),
        .i_start     (w_lg_start),
        .i_x0        (w_x0),
        .i_y0        (w_y0),
        .i_x1        (w_x1),
        .i_y1        (w_y1),
        .o_pix_valid (w_lg_valid),
        .i_pix_ready (w_lg_ready),
        .o_pix_x     (w_lg_x),
        .o_pix_y     (w_lg_y),
        .o_done      (w_lg_done)
    );

endmodule
`default_nettype wire
